base_cdec_pipe: RTL and testbench



---
 rtl/base_cdec_pkg.sv | 18 +
 rtl/base_cdec_therm.sv | 39 +++
 rtl/base_cdec_pipe.sv | 115 +++++++++++
 tb/tb_base_cdec_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/base_cdec_pkg.sv
// Shared constants and helpers for the count decoder pipeline.
package base_cdec_pkg;

  // Output mask shape selected by i_mode.
  localparam logic CDEC_THERM  = 1'b0;
  localparam logic CDEC_ONEHOT = 1'b1;

  // Bits needed to hold the value w, i.e. ceil(log2(w+1)).
  function automatic int clog2_p1(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/base_cdec_therm.sv
// Combinational thermometer expander: sets the first cnt bits of the mask
// (index 0 leftmost). The mask is built by recursive halving, so each level
// splits the count between a left half and a right half.
module base_cdec_therm #(
  parameter int enc_width = 1,
  parameter int dec_width = 1
) (
  input  logic [enc_width-1:0] cnt,
  output logic [0:dec_width-1] therm
);

  if (dec_width == 1) begin : g_leaf
    assign therm[0] = |cnt;
  end else begin : g_split
    localparam int LW = (dec_width + 1) / 2;
    localparam int RW = dec_width - LW;
    localparam logic [enc_width-1:0] LW_C = enc_width'(LW);

    logic [enc_width-1:0] l_cnt;
    logic [enc_width-1:0] r_cnt;

    // Left half takes up to LW of the count; the remainder spills right.
    always_comb begin
      l_cnt = (cnt > LW_C) ? LW_C : cnt;
      r_cnt = (cnt > LW_C) ? (cnt - LW_C) : '0;
    end

    base_cdec_therm #(.enc_width(enc_width), .dec_width(LW)) u_left (
      .cnt   (l_cnt),
      .therm (therm[0:LW-1])
    );

    base_cdec_therm #(.enc_width(enc_width), .dec_width(RW)) u_right (
      .cnt   (r_cnt),
      .therm (therm[LW:dec_width-1])
    );
  end

endmodule

// File: rtl/base_cdec_pipe.sv
// Two-stage elastic count decoder. S1 clamps the count and records
// saturation; S2 holds the expanded thermometer or one-hot mask.
//
// Handshake: a transfer happens on a channel in any cycle where its valid
// and ready are both 1. Valid never drops while waiting for ready, and the
// held data stays stable. Ready is combinational from o_r via
// s2_rdy = !S2.v | o_r and s1_rdy = !S1.v | s2_rdy.
module base_cdec_pipe
  import base_cdec_pkg::*;
#(
  parameter int enc_width = 1,
  parameter int dec_width = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:enc_width-1] i_cnt,
  input  logic                 i_mode,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:dec_width-1] o_mask,
  output logic                 o_sat
);

  // Compare width wide enough for both the raw count and dec_width itself.
  localparam int DW_BITS = clog2_p1(dec_width);
  localparam int CW      = (enc_width > DW_BITS) ? enc_width : DW_BITS;
  localparam logic [CW-1:0] DW_C = CW'(dec_width);

  logic                 s1_v_q, s1_v_d;
  logic [CW-1:0]        s1_c_q, s1_c_d;
  logic                 s1_sat_q, s1_sat_d;
  logic                 s1_mode_q, s1_mode_d;
  logic                 s2_v_q, s2_v_d;
  logic [0:dec_width-1] s2_mask_q, s2_mask_d;
  logic                 s2_sat_q, s2_sat_d;

  logic                 s1_rdy;
  logic                 s2_rdy;
  logic [CW-1:0]        cnt_ext;
  logic [0:dec_width-1] therm;
  logic [0:dec_width-1] onehot;
  logic [0:dec_width-1] mask_nxt;

  assign s2_rdy  = !s2_v_q | o_r;
  assign s1_rdy  = !s1_v_q | s2_rdy;
  assign cnt_ext = CW'(i_cnt);

  base_cdec_therm #(.enc_width(CW), .dec_width(dec_width)) u_therm (
    .cnt   (s1_c_q),
    .therm (therm)
  );

  // One-hot is the falling edge of the thermometer: bit k survives only if
  // bit k+1 is clear (the shift left pulls index k+1 into k, zero-filling
  // the last bit).
  always_comb begin
    onehot   = therm & ~(therm << 1);
    mask_nxt = (s1_mode_q == CDEC_ONEHOT) ? onehot : therm;
  end

  // Next-state for both stages: load when empty or when draining this cycle.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_c_d    = s1_c_q;
    s1_sat_d  = s1_sat_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_mask_d = s2_mask_q;
    s2_sat_d  = s2_sat_q;
    if (s1_rdy) begin
      s1_v_d = i_v;
      if (i_v) begin
        s1_sat_d  = (cnt_ext > DW_C);
        s1_c_d    = (cnt_ext > DW_C) ? DW_C : cnt_ext;
        s1_mode_d = i_mode;
      end
    end
    if (s2_rdy) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_mask_d = mask_nxt;
        s2_sat_d  = s1_sat_q;
      end
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_c_q    <= '0;
      s1_sat_q  <= 1'b0;
      s1_mode_q <= CDEC_THERM;
      s2_v_q    <= 1'b0;
      s2_mask_q <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_c_q    <= s1_c_d;
      s1_sat_q  <= s1_sat_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_mask_q <= s2_mask_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  assign i_r    = s1_rdy;
  assign o_v    = s2_v_q;
  assign o_mask = s2_mask_q;
  assign o_sat  = s2_sat_q;

endmodule

// File: tb/tb_base_cdec_pipe.sv
// Bench for base_cdec_pipe: directed streams, backpressure, random
// handshake traffic against a reference model, async reset, dec_width=1.
module tb_base_cdec_pipe;

  localparam int ENC = 4;
  localparam int DEC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           i_v, i_r, i_mode, o_v, o_r, o_sat;
  logic [0:ENC-1] i_cnt;
  logic [0:DEC-1] o_mask;

  logic       j_v, j_r, j_mode, p_v, p_r, p_sat;
  logic [0:1] j_cnt;
  logic [0:0] p_mask;

  base_cdec_pipe #(.enc_width(ENC), .dec_width(DEC)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_r(i_r), .i_cnt(i_cnt),
    .i_mode(i_mode), .o_v(o_v), .o_r(o_r), .o_mask(o_mask), .o_sat(o_sat)
  );

  base_cdec_pipe #(.enc_width(2), .dec_width(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_v(j_v), .i_r(j_r), .i_cnt(j_cnt),
    .i_mode(j_mode), .o_v(p_v), .o_r(p_r), .o_mask(p_mask), .o_sat(p_sat)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [DEC:0] exp_q[$];
  logic         hold_prev = 1'b0;
  logic [DEC:0] out_prev  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {sat, mask} with mask index 0 leftmost.
  function automatic logic [DEC:0] model(input int cnt, input logic mode);
    int c;
    logic [0:DEC-1] m;
    c = (cnt > DEC) ? DEC : cnt;
    for (int k = 0; k < DEC; k++) m[k] = mode ? (k == c - 1) : (k < c);
    return {cnt > DEC, m};
  endfunction

  // Mid-cycle monitor: record acceptances, compare outputs, check hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_v", 32'(o_v), 32'd1);
        check("hold_data", 32'({o_sat, o_mask}), 32'(out_prev));
      end
      hold_prev = o_v && !o_r;
      out_prev  = {o_sat, o_mask};
      if (i_v && i_r) begin
        exp_q.push_back(model(int'(i_cnt), i_mode));
        n_acc++;
      end
      if (o_v && o_r) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else check("data", 32'({o_sat, o_mask}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int cnt, input logic mode);
    @(posedge clk);
    #1;
    i_v    = v;
    i_cnt  = ENC'(cnt);
    i_mode = mode;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; i_v = 1'b0; i_cnt = '0; i_mode = 1'b0; o_r = 1'b0;
    j_v = 1'b0; j_cnt = '0; j_mode = 1'b0; p_r = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_o_v", 32'(o_v), 32'd0);
    check("rst_mask", 32'(o_mask), 32'd0);
    check("rst_sat", 32'(o_sat), 32'd0);
    check("rst_i_r", 32'(i_r), 32'd1);

    // Thermometer stream with latency check on the first item.
    o_r = 1'b1;
    drive(1, 0, 1'b0);
    drive(1, 3, 1'b0);
    check("lat_early", 32'(o_v), 32'd0);
    drive(1, 8, 1'b0);
    check("lat_v", 32'(o_v), 32'd1);
    check("lat_mask", 32'(o_mask), 32'h00);
    // One-hot stream, then saturation followed by a normal count.
    drive(1, 1, 1'b1);
    drive(1, 5, 1'b1);
    drive(1, 0, 1'b1);
    drive(1, 13, 1'b0);
    drive(1, 2, 1'b0);
    drive(0, 0, 1'b0);
    wait_drain();

    // Backpressure: 4 cycles of o_r=0 with i_v held high.
    @(posedge clk); #1;
    o_r = 1'b0;
    n0 = n_acc;
    i_v = 1'b1; i_cnt = 4'd4; i_mode = 1'b0;
    for (int k = 0; k < 4; k++) drive(1, 6 + k, k[0]);
    check("bp_accepted", 32'(n_acc - n0), 32'd2);
    check("bp_i_r", 32'(i_r), 32'd0);
    i_v = 1'b0;
    o_r = 1'b1;
    wait_drain();

    // Random valid/ready traffic for 10k transfers.
    n0 = n_out;
    for (int cyc = 0; cyc < 60000 && (n_out - n0) < 10000; cyc++) begin
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      o_r = ($urandom_range(0, 99) < 70);
    end
    check("rand_count", 32'((n_out - n0) >= 10000), 32'd1);
    i_v = 1'b0;
    o_r = 1'b1;
    wait_drain();

    // Async reset with both stages full.
    o_r = 1'b0;
    drive(1, 5, 1'b0);
    drive(1, 6, 1'b0);
    drive(1, 7, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    i_v = 1'b0;
    #1;
    check("arst_o_v", 32'(o_v), 32'd0);
    check("arst_mask", 32'(o_mask), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    o_r = 1'b1;
    @(posedge clk); #1;
    check("arst_i_r", 32'(i_r), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1'b0);
      check("arst_stale", 32'(o_v), 32'd0);
    end

    // dec_width = 1: mask = (cnt >= 1), sat = (cnt >= 2), either mode.
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        j_v = 1'b1; j_cnt = 2'(c); j_mode = 1'(m);
        @(posedge clk); #1;
        j_v = 1'b0;
        @(posedge clk); #1;
        check("dw1_v", 32'(p_v), 32'd1);
        check("dw1_out", 32'({p_sat, p_mask}), 32'({c >= 2, c >= 1}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
